// File: rtl/axis_demux_skid.sv
// -----------------------------------------------------------------------------
// axis_demux_skid
// Output register plus temp (skid) register for the destination demux. Holds a
// packed payload and the index of the port it is headed for. Gives full
// throughput while the upstream ready is a pure register, so there is no
// combinational path from m_ready back to the input side.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   int_payload   packed beat from the demux FSM
//   int_tag       destination port index of that beat
//   int_valid     beat is being handed over this cycle
//   ready_int     registered ready towards the demux FSM
//   m_payload     packed payload of the beat on the output
//   m_valid       per-port valid, at most one bit set
//   m_ready       per-port ready
// -----------------------------------------------------------------------------
module axis_demux_skid #(
   parameter int PAYLOAD_WIDTH = 8,
   parameter int M_COUNT       = 4,
   parameter int TAG_WIDTH     = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [PAYLOAD_WIDTH-1:0] int_payload,
   input  logic [TAG_WIDTH-1:0]     int_tag,
   input  logic                     int_valid,
   output logic                     ready_int,
   output logic [PAYLOAD_WIDTH-1:0] m_payload,
   output logic [M_COUNT-1:0]       m_valid,
   input  logic [M_COUNT-1:0]       m_ready
);

   logic                     out_valid;
   logic                     out_valid_next;
   logic [PAYLOAD_WIDTH-1:0] out_payload;
   logic [TAG_WIDTH-1:0]     out_tag;
   logic                     temp_valid;
   logic                     temp_valid_next;
   logic [PAYLOAD_WIDTH-1:0] temp_payload;
   logic [TAG_WIDTH-1:0]     temp_tag;
   logic                     ready_reg;
   logic                     ready_early;
   logic                     m_ready_sel;
   logic                     store_in_to_out;
   logic                     store_in_to_temp;
   logic                     store_temp_to_out;

   // Only the ready of the port currently being presented matters; a stalled
   // port holds the whole stream.
   assign m_ready_sel = out_valid && m_ready[out_tag];

   // Accept next cycle if the output drains now, or if there will still be
   // room somewhere after this cycle's transfer.
   assign ready_early = m_ready_sel || (!temp_valid && (!out_valid || !int_valid));

   always_comb begin
      out_valid_next    = out_valid;
      temp_valid_next   = temp_valid;
      store_in_to_out   = 1'b0;
      store_in_to_temp  = 1'b0;
      store_temp_to_out = 1'b0;
      if (ready_reg) begin
         if (m_ready_sel || !out_valid) begin
            out_valid_next  = int_valid;
            store_in_to_out = 1'b1;
         end else begin
            temp_valid_next  = int_valid;
            store_in_to_temp = 1'b1;
         end
      end else if (m_ready_sel) begin
         out_valid_next    = temp_valid;
         temp_valid_next   = 1'b0;
         store_temp_to_out = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         temp_valid <= 1'b0;
         ready_reg  <= 1'b0;
      end else begin
         out_valid  <= out_valid_next;
         temp_valid <= temp_valid_next;
         ready_reg  <= ready_early;
      end
   end

   // Payload and tag registers carry no reset; the valid flags qualify them.
   always_ff @(posedge clk) begin
      if (store_in_to_out) begin
         out_payload <= int_payload;
         out_tag     <= int_tag;
      end else if (store_temp_to_out) begin
         out_payload <= temp_payload;
         out_tag     <= temp_tag;
      end
      if (store_in_to_temp) begin
         temp_payload <= int_payload;
         temp_tag     <= int_tag;
      end
   end

   always_comb begin
      m_valid = '0;
      if (out_valid) begin
         m_valid[out_tag] = 1'b1;
      end
   end

   assign ready_int = ready_reg;
   assign m_payload = out_payload;

endmodule

// File: rtl/axis_dest_demux.sv
// -----------------------------------------------------------------------------
// axis_dest_demux
// AXI4-Stream frame demultiplexer. The destination port is taken from tdest on
// the first beat of a frame and held until tlast. Frames aimed at a port that
// does not exist, or flagged with drop on their first beat, are swallowed.
// Output goes through a two-entry skid slice (axis_demux_skid).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   s_axis_*        single input stream (tready is an output)
//   m_axis_t*       output payload, shared by all ports
//   m_axis_tvalid   per-port valid, at most one bit set
//   m_axis_tready   per-port ready
//   enable          allows a new frame to start
//   drop            discard the frame whose first beat is on the bus
//   frame_dropped   one-cycle pulse, registered off the tlast handshake of a
//                   discarded frame (appears the cycle after that handshake)
//
// State  | meaning
// IDLE   | no frame open; waiting for a first beat
// PASS   | port latched, forwarding beats
// DROP   | consuming the rest of a discarded frame
// -----------------------------------------------------------------------------
module axis_dest_demux #(
   parameter int M_COUNT     = 4,
   parameter int DATA_WIDTH  = 8,
   parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
   parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
   parameter bit ID_ENABLE   = 1'b0,
   parameter int ID_WIDTH    = 8,
   parameter int DEST_WIDTH  = 8,
   parameter bit USER_ENABLE = 1'b1,
   parameter int USER_WIDTH  = 1
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic [ID_WIDTH-1:0]   s_axis_tid,
   input  logic [DEST_WIDTH-1:0] s_axis_tdest,
   input  logic [USER_WIDTH-1:0] s_axis_tuser,

   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic [M_COUNT-1:0]    m_axis_tvalid,
   input  logic [M_COUNT-1:0]    m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [ID_WIDTH-1:0]   m_axis_tid,
   output logic [DEST_WIDTH-1:0] m_axis_tdest,
   output logic [USER_WIDTH-1:0] m_axis_tuser,

   input  logic                  enable,
   input  logic                  drop,
   output logic                  frame_dropped
);

   localparam int CL_M_COUNT    = $clog2(M_COUNT);
   localparam int PAYLOAD_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
   localparam logic [DEST_WIDTH-1:0] DEST_LIMIT = DEST_WIDTH'(M_COUNT);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PASS = 2'd1;
   localparam logic [1:0] ST_DROP = 2'd2;

   logic [1:0]               state;
   logic [1:0]               state_next;
   logic [CL_M_COUNT-1:0]    sel;
   logic [CL_M_COUNT-1:0]    sel_next;
   logic                     handshake;
   logic                     dest_bad;
   logic                     int_valid;
   logic [CL_M_COUNT-1:0]    int_tag;
   logic                     ready_int;
   logic                     dropped_next;
   logic [KEEP_WIDTH-1:0]    keep_in;
   logic [ID_WIDTH-1:0]      id_in;
   logic [USER_WIDTH-1:0]    user_in;
   logic [PAYLOAD_WIDTH-1:0] int_payload;
   logic [PAYLOAD_WIDTH-1:0] m_payload;

   assign keep_in = KEEP_ENABLE ? s_axis_tkeep : '1;
   assign id_in   = ID_ENABLE   ? s_axis_tid   : '0;
   assign user_in = USER_ENABLE ? s_axis_tuser : '0;

   assign int_payload = {s_axis_tdata, keep_in, s_axis_tlast, id_in, s_axis_tdest, user_in};

   assign dest_bad = (s_axis_tdest >= DEST_LIMIT);

   always_comb begin
      s_axis_tready = 1'b0;
      case (state)
         ST_IDLE: s_axis_tready = enable && ready_int;
         ST_PASS: s_axis_tready = ready_int;
         // Discarded beats never touch the slice, so DROP never stalls.
         ST_DROP: s_axis_tready = 1'b1;
         default: s_axis_tready = 1'b0;
      endcase
   end

   assign handshake = s_axis_tvalid && s_axis_tready;

   always_comb begin
      state_next   = state;
      sel_next     = sel;
      int_valid    = 1'b0;
      int_tag      = sel;
      dropped_next = 1'b0;
      case (state)
         ST_IDLE: begin
            if (handshake) begin
               sel_next = s_axis_tdest[CL_M_COUNT-1:0];
               int_tag  = s_axis_tdest[CL_M_COUNT-1:0];
               if (drop || dest_bad) begin
                  if (s_axis_tlast) begin
                     dropped_next = 1'b1;
                  end else begin
                     state_next = ST_DROP;
                  end
               end else begin
                  int_valid = 1'b1;
                  if (!s_axis_tlast) begin
                     state_next = ST_PASS;
                  end
               end
            end
         end
         ST_PASS: begin
            if (handshake) begin
               int_valid = 1'b1;
               if (s_axis_tlast) begin
                  state_next = ST_IDLE;
               end
            end
         end
         ST_DROP: begin
            if (handshake && s_axis_tlast) begin
               state_next   = ST_IDLE;
               dropped_next = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         frame_dropped <= 1'b0;
      end else begin
         state         <= state_next;
         frame_dropped <= dropped_next;
      end
   end

   always_ff @(posedge clk) begin
      sel <= sel_next;
   end

   axis_demux_skid #(
      .PAYLOAD_WIDTH(PAYLOAD_WIDTH),
      .M_COUNT      (M_COUNT),
      .TAG_WIDTH    (CL_M_COUNT)
   ) u_skid (
      .clk        (clk),
      .rst        (rst),
      .int_payload(int_payload),
      .int_tag    (int_tag),
      .int_valid  (int_valid),
      .ready_int  (ready_int),
      .m_payload  (m_payload),
      .m_valid    (m_axis_tvalid),
      .m_ready    (m_axis_tready)
   );

   assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser} = m_payload;

endmodule

// File: tb/tb_axis_dest_demux.sv
module tb_axis_dest_demux;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] s_tdata;
   logic [0:0] s_tkeep;
   logic       s_tvalid;
   logic       s_tready;
   logic       s_tlast;
   logic [7:0] s_tid;
   logic [7:0] s_tdest;
   logic [0:0] s_tuser;
   logic [7:0] m_tdata;
   logic [0:0] m_tkeep;
   logic [3:0] m_tvalid;
   logic [3:0] m_tready;
   logic       m_tlast;
   logic [7:0] m_tid;
   logic [7:0] m_tdest;
   logic [0:0] m_tuser;
   logic       enable;
   logic       drop;
   logic       frame_dropped;

   always #5 clk = ~clk;

   axis_dest_demux #(
      .M_COUNT(4), .DATA_WIDTH(8), .KEEP_ENABLE(1'b0), .KEEP_WIDTH(1),
      .ID_ENABLE(1'b0), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_ENABLE(1'b1), .USER_WIDTH(1)
   ) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
      .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
      .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
      .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser),
      .enable(enable), .drop(drop), .frame_dropped(frame_dropped)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // packed record of an output transfer: port, tdest, tuser, tlast, tdata
   function automatic logic [21:0] pk(input int port, input logic [7:0] dest,
                                      input logic user, input logic last, input logic [7:0] data);
      logic [3:0] p;
      p = port[3:0];
      return {p, dest, user, last, data};
   endfunction

   logic [21:0] rx_q[$];
   int          rx_cyc_q[$];
   int          drop_cnt = 0;
   int          drop_cyc = -1;
   int          multi_err = 0;
   int          stab_err = 0;
   logic        prev_stall = 1'b0;
   logic [3:0]  prev_v = '0;
   logic [21:0] prev_p = '0;

   always @(negedge clk) begin
      if ($countones(m_tvalid) > 1) multi_err <= multi_err + 1;
      if (prev_stall && (m_tvalid !== prev_v || pk(0, m_tdest, m_tuser[0], m_tlast, m_tdata) !== prev_p))
         stab_err <= stab_err + 1;
      prev_stall <= (|(m_tvalid & ~m_tready)) && !rst;
      prev_v     <= m_tvalid;
      prev_p     <= pk(0, m_tdest, m_tuser[0], m_tlast, m_tdata);
      for (int i = 0; i < 4; i++) begin
         if (m_tvalid[i] && m_tready[i]) begin
            rx_q.push_back(pk(i, m_tdest, m_tuser[0], m_tlast, m_tdata));
            rx_cyc_q.push_back(cyc);
         end
      end
      if (frame_dropped) begin
         drop_cnt <= drop_cnt + 1;
         drop_cyc <= cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] d, input logic [7:0] dest, input logic last,
                       input logic drp, input logic user, output int waits, output int hcyc);
      logic ok;
      ok = 1'b0;
      waits = 0;
      hcyc = -1;
      s_tvalid = 1'b1;
      s_tdata = d;
      s_tdest = dest;
      s_tlast = last;
      drop = drp;
      s_tuser = user;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (s_tready) begin
            ok = 1'b1;
            hcyc = cyc;
         end else begin
            waits++;
         end
         @(posedge clk);
         #1;
      end
      s_tvalid = 1'b0;
      drop = 1'b0;
      check("send_handshake", {31'd0, ok}, 32'd1);
   endtask

   task automatic expect_rx(input string tag, input logic [21:0] exp, output int rc);
      logic [21:0] got;
      logic        present;
      rc = -1;
      present = (rx_q.size() > 0);
      check({tag, "_present"}, {31'd0, present}, 32'd1);
      if (present) begin
         got = rx_q.pop_front();
         rc = rx_cyc_q.pop_front();
         check(tag, {10'd0, got}, {10'd0, exp});
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   int w, h, h0, h4, rc, d0;

   initial begin
      rst = 1'b1;
      s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
      s_tid = 8'hA5; s_tdest = '0; s_tuser = '0;
      m_tready = 4'hF; enable = 1'b1; drop = 1'b0;
      tick(3);
      // reset state
      check("rst_m_tvalid", {28'd0, m_tvalid}, 32'd0);
      check("rst_s_tready", {31'd0, s_tready}, 32'd0);
      check("rst_frame_dropped", {31'd0, frame_dropped}, 32'd0);
      rst = 1'b0;
      tick(1);
      check("post_rst_s_tready", {31'd0, s_tready}, 32'd1);

      // 3-beat frame to port 2, all ready
      send(8'h11, 8'd2, 1'b0, 1'b0, 1'b0, w, h0);
      send(8'h22, 8'd2, 1'b0, 1'b0, 1'b1, w, h);
      check("t1_beat2_nowait", w, 0);
      send(8'h33, 8'd2, 1'b1, 1'b0, 1'b0, w, h);
      check("t1_beat3_nowait", w, 0);
      check("t1_tkeep_ones", {31'd0, m_tkeep}, 32'd1);
      check("t1_tid_zero", {24'd0, m_tid}, 32'd0);
      tick(3);
      expect_rx("t1_b0", pk(2, 8'd2, 1'b0, 1'b0, 8'h11), rc);
      check("t1_b0_cyc", rc, h0 + 1);
      expect_rx("t1_b1", pk(2, 8'd2, 1'b1, 1'b0, 8'h22), rc);
      check("t1_b1_cyc", rc, h0 + 2);
      expect_rx("t1_b2", pk(2, 8'd2, 1'b0, 1'b1, 8'h33), rc);
      check("t1_b2_cyc", rc, h0 + 3);
      check("t1_no_extra", rx_q.size(), 0);

      // 4-beat frame to nonexistent port 5
      d0 = drop_cnt;
      send(8'h50, 8'd5, 1'b0, 1'b0, 1'b0, w, h);
      check("t2_b0_nowait", w, 0);
      send(8'h51, 8'd5, 1'b0, 1'b0, 1'b0, w, h);
      check("t2_b1_nowait", w, 0);
      send(8'h52, 8'd5, 1'b0, 1'b0, 1'b0, w, h);
      check("t2_b2_nowait", w, 0);
      send(8'h53, 8'd5, 1'b1, 1'b0, 1'b0, w, h4);
      check("t2_b3_nowait", w, 0);
      tick(3);
      check("t2_drop_count", drop_cnt - d0, 1);
      check("t2_drop_cyc", drop_cyc, h4 + 1);
      check("t2_no_rx", rx_q.size(), 0);

      // dropped frame to port 1, then a kept frame to port 1
      d0 = drop_cnt;
      send(8'h44, 8'd1, 1'b0, 1'b1, 1'b0, w, h);
      send(8'h45, 8'd1, 1'b1, 1'b0, 1'b0, w, h);
      send(8'h55, 8'd1, 1'b0, 1'b0, 1'b0, w, h);
      send(8'h66, 8'd1, 1'b1, 1'b0, 1'b0, w, h);
      tick(3);
      check("t3_drop_count", drop_cnt - d0, 1);
      expect_rx("t3_b0", pk(1, 8'd1, 1'b0, 1'b0, 8'h55), rc);
      expect_rx("t3_b1", pk(1, 8'd1, 1'b0, 1'b1, 8'h66), rc);
      check("t3_no_extra", rx_q.size(), 0);

      // port 0 stalled for 5 cycles mid-frame
      send(8'hA0, 8'd0, 1'b0, 1'b0, 1'b0, w, h);
      send(8'hA1, 8'd0, 1'b0, 1'b0, 1'b0, w, h);
      m_tready = 4'b1110;
      send(8'hA2, 8'd0, 1'b0, 1'b0, 1'b0, w, h);
      check("t4_tready_low", {31'd0, s_tready}, 32'd0);
      check("t4_hold_valid", {28'd0, m_tvalid}, 32'h1);
      check("t4_hold_data", {24'd0, m_tdata}, 32'hA1);
      s_tvalid = 1'b1; s_tdata = 8'hA3; s_tdest = 8'd0; s_tlast = 1'b0; s_tuser = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         check("t4_stall_tready", {31'd0, s_tready}, 32'd0);
         check("t4_stall_data", {24'd0, m_tdata}, 32'hA1);
      end
      m_tready = 4'hF;
      send(8'hA3, 8'd0, 1'b0, 1'b0, 1'b0, w, h);
      send(8'hA4, 8'd0, 1'b0, 1'b0, 1'b0, w, h);
      send(8'hA5, 8'd0, 1'b1, 1'b0, 1'b0, w, h);
      tick(4);
      expect_rx("t4_b0", pk(0, 8'd0, 1'b0, 1'b0, 8'hA0), rc);
      expect_rx("t4_b1", pk(0, 8'd0, 1'b0, 1'b0, 8'hA1), rc);
      expect_rx("t4_b2", pk(0, 8'd0, 1'b0, 1'b0, 8'hA2), rc);
      expect_rx("t4_b3", pk(0, 8'd0, 1'b0, 1'b0, 8'hA3), rc);
      expect_rx("t4_b4", pk(0, 8'd0, 1'b0, 1'b0, 8'hA4), rc);
      expect_rx("t4_b5", pk(0, 8'd0, 1'b0, 1'b1, 8'hA5), rc);
      check("t4_no_extra", rx_q.size(), 0);
      check("t4_stability", stab_err, 0);

      // back-to-back single-beat frames
      send(8'hB0, 8'd0, 1'b1, 1'b0, 1'b0, w, h0);
      check("t5_f0_nowait", w, 0);
      send(8'hB1, 8'd1, 1'b1, 1'b0, 1'b0, w, h);
      check("t5_f1_nowait", w, 0);
      send(8'hB2, 8'd2, 1'b1, 1'b0, 1'b0, w, h);
      check("t5_f2_nowait", w, 0);
      send(8'hB3, 8'd3, 1'b1, 1'b0, 1'b0, w, h);
      check("t5_f3_nowait", w, 0);
      send(8'hB4, 8'd0, 1'b1, 1'b0, 1'b0, w, h);
      check("t5_f4_nowait", w, 0);
      check("t5_span", h - h0, 4);
      tick(3);
      expect_rx("t5_f0", pk(0, 8'd0, 1'b0, 1'b1, 8'hB0), rc);
      check("t5_f0_cyc", rc, h0 + 1);
      expect_rx("t5_f1", pk(1, 8'd1, 1'b0, 1'b1, 8'hB1), rc);
      check("t5_f1_cyc", rc, h0 + 2);
      expect_rx("t5_f2", pk(2, 8'd2, 1'b0, 1'b1, 8'hB2), rc);
      check("t5_f2_cyc", rc, h0 + 3);
      expect_rx("t5_f3", pk(3, 8'd3, 1'b0, 1'b1, 8'hB3), rc);
      check("t5_f3_cyc", rc, h0 + 4);
      expect_rx("t5_f4", pk(0, 8'd0, 1'b0, 1'b1, 8'hB4), rc);
      check("t5_f4_cyc", rc, h0 + 5);
      check("t5_no_extra", rx_q.size(), 0);

      // enable gating, enable ignored mid-frame, reset mid-frame
      enable = 1'b0;
      s_tvalid = 1'b1; s_tdata = 8'hC0; s_tdest = 8'd3; s_tlast = 1'b0; s_tuser = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check("t6_disabled_tready", {31'd0, s_tready}, 32'd0);
      end
      check("t6_disabled_no_rx", rx_q.size(), 0);
      enable = 1'b1;
      send(8'hC0, 8'd3, 1'b0, 1'b0, 1'b0, w, h);
      check("t6_c0_nowait", w, 0);
      enable = 1'b0;
      send(8'hC1, 8'd3, 1'b0, 1'b0, 1'b0, w, h);
      check("t6_c1_enable_ignored", w, 0);
      send(8'hC2, 8'd3, 1'b0, 1'b0, 1'b0, w, h);
      check("t6_c2_enable_ignored", w, 0);
      enable = 1'b1;
      check("t6_c2_on_output", {28'd0, m_tvalid}, 32'h8);
      rst = 1'b1;
      m_tready = 4'h0;
      tick(1);
      check("t6_rst_m_tvalid", {28'd0, m_tvalid}, 32'd0);
      check("t6_rst_s_tready", {31'd0, s_tready}, 32'd0);
      check("t6_rst_frame_dropped", {31'd0, frame_dropped}, 32'd0);
      rst = 1'b0;
      m_tready = 4'hF;
      tick(1);
      send(8'hD0, 8'd1, 1'b1, 1'b0, 1'b0, w, h);
      tick(3);
      expect_rx("t6_c0", pk(3, 8'd3, 1'b0, 1'b0, 8'hC0), rc);
      expect_rx("t6_c1", pk(3, 8'd3, 1'b0, 1'b0, 8'hC1), rc);
      expect_rx("t6_d0_new_frame", pk(1, 8'd1, 1'b0, 1'b1, 8'hD0), rc);
      check("t6_no_extra", rx_q.size(), 0);

      // tdest exactly M_COUNT: single-beat frame dropped
      d0 = drop_cnt;
      send(8'hE0, 8'd4, 1'b1, 1'b0, 1'b0, w, h);
      tick(3);
      check("t7_drop_count", drop_cnt - d0, 1);
      check("t7_drop_cyc", drop_cyc, h + 1);
      check("t7_no_rx", rx_q.size(), 0);

      check("onehot_valid", multi_err, 0);
      check("payload_stability", stab_err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
